ram_seq_controller: RTL and testbench
=====================================

Name: ram_seq_controller

Overview:
- Initiator for the nx4 synchronous RAM in the memory-game datapath.
- Records a sequence of 4-bit plays into the RAM and plays the stored sequence back through a valid/ready stream.
- Owns the RAM port signals (we, data, addr) and consumes its registered-address read data (one-cycle read latency).
- Sits between the game control unit and the RAM instance.

Parameters:
- N, 256, RAM depth in words. Must be a power of two, ≥ 2. AW = $clog2(N).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  empties the stored sequence; aborts any playback
- wr_valid  in  1  append request
- wr_data  in  4  nibble to append
- wr_ready  out  1  append accepted this cycle when wr_valid is also high
- play_start  in  1  starts playback of entries 0 .. len-1
- play_data  out  4  current playback nibble
- play_valid  out  1  play_data valid
- play_ready  in  1  consumer accepts play_data
- play_done  out  1  one-cycle pulse when playback finishes
- busy  out  1  high in any state other than IDLE
- len  out  AW+1  number of stored entries, 0..N
- full  out  1  len == N
- ram_we  out  1  to RAM we
- ram_data  out  4  to RAM data
- ram_addr  out  AW  to RAM addr
- ram_q  in  4  from RAM q; valid the cycle after ram_addr is presented

Behaviour:
- Reset values (asynchronous):
  - state = IDLE; len = 0; rd_ptr = 0.
  - play_valid = 0; play_data = 0; play_done = 0.
  - ram_we = 0 (combinational from state).
- States: IDLE, FETCH, LATCH, HOLD.
- wr_ready = (state == IDLE) && !full && !play_start && !clear. Combinational.
- Write:
  - When wr_valid && wr_ready: ram_we = 1, ram_addr = len[AW-1:0], ram_data = wr_data, all in the same cycle.
  - len increments at that edge.
  - Otherwise ram_we = 0 and ram_data = wr_data.
- Writes are never accepted when full or busy. Writing when full does not wrap, and len never exceeds N.
- Playback start, in IDLE with play_start:
  - If len == 0: play_done = 1 for the next cycle only; stay IDLE.
  - Otherwise: rd_ptr = 0, go to FETCH.
- FETCH: ram_addr = rd_ptr. Next state LATCH.
- LATCH: ram_q holds RAM[rd_ptr]. At the edge, play_data ← ram_q, play_valid ← 1. Next state HOLD.
- HOLD:
  - play_valid stays high; play_data holds stable until play_ready.
  - On play_valid && play_ready:
    - play_valid ← 0.
    - If rd_ptr == len-1: play_done = 1 for the next cycle only; go IDLE.
    - Otherwise: rd_ptr increments; go FETCH.
- Timing:
  - First play_valid appears 3 cycles after the play_start cycle.
  - Throughput is one nibble per 3 cycles when play_ready is held high.
- ram_addr in IDLE = len[AW-1:0]. In LATCH and HOLD it holds rd_ptr.
- clear has the highest priority, in any state:
  - next state IDLE; len = 0; rd_ptr = 0; play_valid = 0.
  - No play_done pulse.
  - Any simultaneous write or play_start is ignored.
- play_start has priority over wr_valid in the same IDLE cycle. play_start outside IDLE is ignored.
- Playback does not modify RAM contents or len. Repeated playbacks return identical data.
- RAM contents are not cleared by reset or clear. Only len defines valid data.

Test Plan:
- Reset mid-playback (assert reset while in HOLD) -> all outputs reset immediately without a clock edge: len = 0, play_valid = 0, busy = 0.
- Write 3, A, 5 on consecutive cycles with wr_valid high -> ram_we high for 3 cycles with ram_addr 0, 1, 2; len = 3.
- Playback of that sequence with play_ready tied high:
  - play_start at cycle 0 -> play_valid in cycles 3, 6, 9 with play_data 3, A, 5.
  - play_done pulse in cycle 10; busy low from cycle 10.
- Backpressure: hold play_ready low for 5 cycles after the first valid -> play_data stays 3 and play_valid stays high; the next item follows 3 cycles after the handshake.
- Full boundary with N=4:
  - Write 4 nibbles -> full = 1, len = 4, wr_ready = 0.
  - A fifth wr_valid -> ram_we stays 0 and len stays 4.
  - Playback returns all 4 values in order.
- Empty and clear:
  - play_start with len = 0 -> play_done one cycle later, no play_valid.
  - clear during HOLD -> IDLE next cycle, play_valid = 0, len = 0, no play_done.
  - Simultaneous play_start + wr_valid in IDLE -> no write; playback starts.

Source files
------------

// File: rtl/ram_seq_controller.sv
// ram_seq_controller: records 4-bit plays into an nx4 sync RAM and streams them back via valid/ready.
module ram_seq_controller #(
  parameter int N = 256,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          wr_valid,
  input  logic [3:0]    wr_data,
  output logic          wr_ready,
  input  logic          play_start,
  output logic [3:0]    play_data,
  output logic          play_valid,
  input  logic          play_ready,
  output logic          play_done,
  output logic          busy,
  output logic [AW:0]   len,
  output logic          full,
  output logic          ram_we,
  output logic [3:0]    ram_data,
  output logic [AW-1:0] ram_addr,
  input  logic [3:0]    ram_q
);
  typedef enum logic [1:0] {IDLE, FETCH, LATCH, HOLD} state_t;
  state_t state, state_nx;
  logic [AW-1:0] rd_ptr;
  logic last;
  assign full = len == (AW+1)'(N);
  assign busy = state != IDLE;
  assign wr_ready = state == IDLE && !full && !play_start && !clear;
  assign ram_we = wr_valid && wr_ready;
  assign ram_data = wr_data;
  // idle addresses the next free slot so a write needs no extra cycle
  assign ram_addr = busy ? rd_ptr : len[AW-1:0];
  assign last = {1'b0, rd_ptr} == len - (AW+1)'(1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = play_start && |len ? FETCH : IDLE;
      FETCH: state_nx = LATCH;
      LATCH: state_nx = HOLD;
      HOLD:  state_nx = play_ready ? (last ? IDLE : FETCH) : HOLD;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      len <= '0;
      rd_ptr <= '0;
      play_valid <= 1'b0;
      play_data <= '0;
      play_done <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      len <= '0;
      rd_ptr <= '0;
      play_valid <= 1'b0;
      play_done <= 1'b0;
    end else begin
      state <= state_nx;
      play_done <= (state == IDLE && play_start && !(|len)) || (state == HOLD && play_ready && last);
      if (ram_we) len <= len + (AW+1)'(1);
      if (state == IDLE && play_start) rd_ptr <= '0;
      if (state == HOLD && play_ready && !last) rd_ptr <= rd_ptr + AW'(1);
      if (state == LATCH) begin
        play_data <= ram_q;
        play_valid <= 1'b1;
      end
      if (state == HOLD && play_ready) play_valid <= 1'b0;
    end
endmodule

// File: tb/tb_ram_seq_controller.sv
// tb_ram_seq_controller: directed bench with a playback scoreboard for ram_seq_controller (N=4).
module tb_ram_seq_controller;
  localparam int N = 4;
  localparam int AW = 2;
  logic clk = 0, reset, clear, wr_valid, wr_ready, play_start, play_valid, play_ready, play_done;
  logic busy, full, ram_we;
  logic [3:0] wr_data, play_data, ram_data, ram_q;
  logic [AW:0] len;
  logic [AW-1:0] ram_addr;
  logic [3:0] mem [N];
  logic [3:0] sb [$];
  int compared = 0, mismatched = 0;

  ram_seq_controller #(.N(N)) dut (
    .clk(clk), .reset(reset), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .play_start(play_start), .play_data(play_data), .play_valid(play_valid),
    .play_ready(play_ready), .play_done(play_done), .busy(busy), .len(len), .full(full),
    .ram_we(ram_we), .ram_data(ram_data), .ram_addr(ram_addr), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // RAM with registered address: q follows addr by one cycle
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset && play_valid && play_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_item", 1, 0);
      else chk("sb_play_data", play_data, sb.pop_front());
    end

  task automatic wr(input logic [3:0] v, input int addr);
    wr_valid = 1;
    wr_data = v;
    @(negedge clk);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, addr);
    chk("wr_ram_data", ram_data, v);
    @(posedge clk); #1;
    wr_valid = 0;
  endtask

  task automatic play(input int items, input int ready_from, input logic wv,
                      input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3);
    logic [3:0] d [4];
    int nv, left, done_c, k;
    logic ev, finished;
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < items; i++) sb.push_back(d[i]);
    play_start = 1;
    wr_valid = wv;
    wr_data = 4'hF;
    play_ready = ready_from <= 0;
    @(negedge clk);
    chk("start_no_write", ram_we, 0);
    @(posedge clk); #1;
    play_start = 0;
    wr_valid = 0;
    nv = 3;
    left = items;
    k = 0;
    done_c = items == 0 ? 1 : -1;
    finished = 0;
    for (int c = 1; c <= 100; c++) begin
      play_ready = c >= ready_from;
      ev = left > 0 && c >= nv;
      @(negedge clk);
      chk("play_valid", play_valid, ev);
      chk("play_done", play_done, c == done_c);
      chk("busy", busy, c != done_c);
      if (ev) chk("play_data", play_data, d[k]);
      if (ev && play_ready) begin
        left--;
        k++;
        nv = c + 3;
        if (left == 0) done_c = c + 1;
      end
      @(posedge clk); #1;
      if (c == done_c) begin
        finished = 1;
        break;
      end
    end
    chk("play_finished", finished, 1);
    play_ready = 0;
  endtask

  initial begin
    reset = 1; clear = 0; wr_valid = 0; wr_data = 0; play_start = 0; play_ready = 0;
    #1;
    chk("rst_len", len, 0);
    chk("rst_play_valid", play_valid, 0);
    chk("rst_play_done", play_done, 0);
    chk("rst_play_data", play_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_we", ram_we, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;

    wr(4'h3, 0); wr(4'hA, 1); wr(4'h5, 2);
    @(negedge clk);
    chk("len_3", len, 3);
    chk("not_full", full, 0);
    chk("wr_ready_idle", wr_ready, 1);
    @(posedge clk); #1;

    play(3, 0, 0, 4'h3, 4'hA, 4'h5, 4'h0);
    play(3, 8, 0, 4'h3, 4'hA, 4'h5, 4'h0);
    @(negedge clk);
    chk("len_after_play", len, 3);
    @(posedge clk); #1;

    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    @(negedge clk);
    chk("clear_len", len, 0);
    @(posedge clk); #1;
    play(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);

    wr(4'h1, 0); wr(4'h2, 1);
    play_start = 1;
    @(posedge clk); #1;
    play_start = 0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("hold_valid", play_valid, 1);
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    @(negedge clk);
    chk("clr_hold_valid", play_valid, 0);
    chk("clr_hold_len", len, 0);
    chk("clr_hold_busy", busy, 0);
    chk("clr_hold_done", play_done, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("clr_hold_done2", play_done, 0);
    @(posedge clk); #1;

    wr(4'hA, 0); wr(4'hB, 1); wr(4'hC, 2);
    play(3, 0, 1, 4'hA, 4'hB, 4'hC, 4'h0);
    @(negedge clk);
    chk("len_after_simul", len, 3);
    @(posedge clk); #1;

    wr(4'hD, 3);
    @(negedge clk);
    chk("full_flag", full, 1);
    chk("full_len", len, 4);
    chk("full_wr_ready", wr_ready, 0);
    @(posedge clk); #1;
    wr_valid = 1;
    wr_data = 4'h7;
    @(negedge clk);
    chk("full_ram_we", ram_we, 0);
    @(posedge clk); #1;
    wr_valid = 0;
    @(negedge clk);
    chk("full_len_hold", len, 4);
    @(posedge clk); #1;
    play(4, 0, 0, 4'hA, 4'hB, 4'hC, 4'hD);

    play_start = 1;
    @(posedge clk); #1;
    play_start = 0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_reset_valid", play_valid, 1);
    #1 reset = 1;
    #1;
    chk("async_rst_len", len, 0);
    chk("async_rst_valid", play_valid, 0);
    chk("async_rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 0;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
